// File: rtl/sample_loader.sv
// Streaming loader that writes one frame of N = 2^ADDR_W samples into RAM port A.
// Build option SAMPLE_LOADER_BITREV_EN selects bit-reversed addressing; without it, addresses are in natural order.
module sample_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              sample_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [ADDR_W-1:0] addrA,
  output logic [DATA_W-1:0] DinA,
  output logic              write_enableA
);

  localparam int N = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [ADDR_W:0] cnt;
  logic            accept;
  logic            frame_start;

  // With bit reversal, sample n lands at its decimation-in-time position.
  // Without it, a separate reorder pass must run before the FFT.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] n);
    logic [ADDR_W-1:0] r;
`ifdef SAMPLE_LOADER_BITREV_EN
    for (int i = 0; i < ADDR_W; i++) r[i] = n[ADDR_W-1-i];
`else
    r = n;
`endif
    return r;
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next   = state;
    sample_ready = (state == ST_LOAD);
    busy         = (state != ST_IDLE);
    accept       = sample_valid && (state == ST_LOAD);
    frame_start  = start && (state == ST_IDLE);
    case (state)
      ST_IDLE: if (start) state_next = ST_LOAD;
      ST_LOAD: if (accept && (cnt == LAST_IDX)) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      done          <= 1'b0;
      overrun       <= 1'b0;
      addrA         <= '0;
      DinA          <= '0;
      write_enableA <= 1'b0;
    end else begin
      state         <= state_next;
      done          <= (state == ST_DONE);
      write_enableA <= accept;

      if (frame_start) cnt <= '0;
      else if (accept) cnt <= cnt + 1'b1;

      // Address and data hold their last values between strobes.
      if (accept) begin
        addrA <= map_addr(cnt[ADDR_W-1:0]);
        DinA  <= sample_data;
      end

      // Starting a new frame clears overrun. A clear in the same cycle as a set wins.
      if (frame_start) overrun <= 1'b0;
      else if (sample_valid && (state != ST_LOAD)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sample_loader.sv
// Self-checking bench for sample_loader (ADDR_W=3, DATA_W=32): the expected write sequence is queued at drive time
// and popped by a write monitor.
module tb_sample_loader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int N      = 8;

  logic              Clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] sample_data = '0;
  logic              sample_ready, busy, done, overrun, write_enableA;
  logic [ADDR_W-1:0] addrA;
  logic [DATA_W-1:0] DinA;

  always #5 Clk = ~Clk;

  sample_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .Clk           (Clk),
    .reset         (reset),
    .start         (start),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .sample_ready  (sample_ready),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun),
    .addrA         (addrA),
    .DinA          (DinA),
    .write_enableA (write_enableA)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_got, mon_exp;
  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  wr_count = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [ADDR_W-1:0] exp_addr(input int n);
    logic [2:0] v;
    v = 3'(n);
`ifdef SAMPLE_LOADER_BITREV_EN
    return {v[0], v[1], v[2]};
`else
    return v;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] sample_val(input int n);
    return {16'(n), 16'(n)};
  endfunction

  // Write monitor: each strobe must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (write_enableA === 1'b1) begin
      wr_count++;
      n_checks++;
      mon_got = {addrA, DinA};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", addrA, DinA);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL write_seq: got addr=%0d data=%h, required addr=%0d data=%h",
                   mon_got.addr, mon_got.data, mon_exp.addr, mon_exp.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int first, input int count, input bit gaps);
    for (int n = first; n < first + count; n++) begin
      sample_valid = 1'b1;
      sample_data  = sample_val(n);
      exp_q.push_back(wr_t'({exp_addr(n), sample_val(n)}));
      tick();
      if (gaps) begin
        sample_valid = 1'b0;
        sample_data  = 32'hDEAD_BEEF;
        tick();
      end
    end
    sample_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int seen);
    seen = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (done === 1'b1) begin
        seen = cyc;
        break;
      end
    end
  endtask

  task automatic check_done_at(input string name, input int seen, input int required);
    n_checks++;
    if (seen !== required) begin
      n_fail++;
      $display("FAIL %s: done seen in cycle %0d, required cycle %0d", name, seen, required);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    sample_valid = 1'b1;
    sample_data = 32'hFFFF_FFFF;
    repeat (3) @(negedge Clk);
    n_checks++;
    if ({sample_ready, busy, done, overrun, write_enableA, addrA, DinA} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0",
               {sample_ready, busy, done, overrun, write_enableA, addrA, DinA});
    end
    start = 1'b0;
    sample_valid = 1'b0;
    @(negedge Clk);
    reset = 1'b1;
    tick();
    @(negedge Clk);
    n_checks++;
    if ({sample_ready, busy, done, overrun, write_enableA, addrA, DinA} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h, required 0",
               {sample_ready, busy, done, overrun, write_enableA, addrA, DinA});
    end
  endtask

  task automatic test_continuous();
    int s, d, w0;
    tick();
    w0 = wr_count;
    pulse_start(s);
    @(negedge Clk);
    n_checks++;
    if ({busy, sample_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL load_entry: got busy/ready=%b, required 11", {busy, sample_ready});
    end
    feed(0, N, 1'b0);
    wait_done(30, d);
    check_done_at("continuous_done", d, s + 10);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_fall: got busy=%b in done cycle, required 0", busy);
    end
    @(negedge Clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got done=%b one cycle later, required 0", done);
    end
    n_checks++;
    if (wr_count - w0 != N || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL continuous_writes: got %0d writes (%0d pending), required %0d (0 pending)",
               wr_count - w0, exp_q.size(), N);
    end
  endtask

  task automatic test_stall();
    int s, d, w0;
    tick();
    w0 = wr_count;
    pulse_start(s);
    feed(0, N, 1'b1);
    wait_done(30, d);
    check_done_at("stall_done", d, s + 17);
    @(negedge Clk);
    n_checks++;
    if (wr_count - w0 != N || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_writes: got %0d writes (%0d pending), required %0d (0 pending)",
               wr_count - w0, exp_q.size(), N);
    end
  endtask

  task automatic test_overrun();
    int s, d, w0;
    tick();
    w0 = wr_count;
    sample_valid = 1'b1;
    sample_data = 32'h1234_5678;
    tick();
    tick();
    sample_valid = 1'b0;
    @(negedge Clk);
    n_checks++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got overrun=%b, required 1", overrun);
    end
    @(negedge Clk);
    n_checks++;
    if (wr_count != w0) begin
      n_fail++;
      $display("FAIL overrun_no_write: got %0d writes, required 0", wr_count - w0);
    end
    tick();
    pulse_start(s);
    @(negedge Clk);
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got overrun=%b after start, required 0", overrun);
    end
    feed(0, N, 1'b0);
    wait_done(30, d);
    check_done_at("overrun_frame_done", d, s + 10);
  endtask

  task automatic test_back_to_back();
    int s1, s2, d;
    tick();
    pulse_start(s1);
    feed(0, N, 1'b0);
    tick();
    start = 1'b1;
    s2 = cyc;
    @(negedge Clk);
    n_checks++;
    if (done !== 1'b1 || cyc != s1 + 10) begin
      n_fail++;
      $display("FAIL b2b_first_done: got done=%b in cycle %0d, required 1 in cycle %0d", done, cyc, s1 + 10);
    end
    tick();
    start = 1'b0;
    n_checks++;
    if ({busy, sample_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_no_gap: got busy/ready=%b, required 11", {busy, sample_ready});
    end
    feed(0, 1, 1'b0);
    @(negedge Clk);
    n_checks++;
    if (write_enableA !== 1'b1 || addrA !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_first_addr: got we=%b addr=%0d, required we=1 addr=0", write_enableA, addrA);
    end
    feed(1, N - 1, 1'b0);
    wait_done(30, d);
    check_done_at("b2b_second_done", d, s2 + 10);
  endtask

  task automatic test_reset_mid();
    int s, d;
    tick();
    pulse_start(s);
    feed(0, 3, 1'b0);
    @(negedge Clk);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({sample_ready, busy, done, overrun, write_enableA, addrA, DinA} !== '0) begin
      n_fail++;
      $display("FAIL midframe_reset: got %h, required 0",
               {sample_ready, busy, done, overrun, write_enableA, addrA, DinA});
    end
    repeat (2) @(negedge Clk);
    reset = 1'b1;
    tick();
    n_checks++;
    if ({busy, sample_ready, done} !== 3'b000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got busy/ready/done=%b pending=%0d, required 000 pending=0",
               {busy, sample_ready, done}, exp_q.size());
    end
    pulse_start(s);
    feed(0, N, 1'b0);
    wait_done(30, d);
    check_done_at("post_reset_frame_done", d, s + 10);
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge Clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: got %0d pending writes, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_loader.md
# sample_loader

Streaming front-end that fills the FFT input RAM with one frame of samples, writing each sample directly to its bit-reversed address. It sits between the sample source (ADC/test pattern) and write port A of the input dual-port RAM. When a frame is complete the RAM holds decimation-in-time order, so the FFT butterfly engine can start without a separate reorder pass. `done` is the hand-off to that engine.

## Interface
Parameters:
- `DATA_W`, 32 — sample width in bits; packed complex {re[31:16], im[15:0]}, passed through untouched.
- `ADDR_W`, 5 — log2 of frame length; N = 2^ADDR_W points.

Ports:
- `Clk` in 1 — single clock; all logic is rising-edge.
- `reset` in 1 — asynchronous, active-low; asserting it (0) clears all state immediately.
- `start` in 1 — frame request; sampled only in IDLE.
- `sample_valid` in 1 — source has a sample on `sample_data`.
- `sample_data` in DATA_W — sample value.
- `sample_ready` out 1 — loader accepts a sample this cycle.
- `busy` out 1 — high in LOAD and DONE.
- `done` out 1 — one-cycle pulse: frame fully written to RAM.
- `overrun` out 1 — sticky: `sample_valid` was seen while not loading.
- `addrA` out ADDR_W — RAM port A address.
- `DinA` out DATA_W — RAM port A write data.
- `write_enableA` out 1 — RAM port A write strobe.

## Operation
- States: IDLE, LOAD, DONE. Reset enters IDLE.
- Reset values: all outputs 0; internal sample counter 0.
- IDLE → LOAD when `start`=1. Entering LOAD clears the counter and clears `overrun`.
- LOAD:
  - `sample_ready` = 1; it is a combinational decode of state == LOAD.
  - A sample is accepted on each cycle with `sample_valid & sample_ready`.
  - Accepted sample n is written to `addrA` = bitrev(n), i.e. bit i of the address = bit ADDR_W-1-i of n.
  - After the write is issued, the counter increments.
  - LOAD → DONE on acceptance of sample N-1.
- DONE lasts exactly 1 cycle, then → IDLE. `done` = 1 in the first IDLE cycle after DONE.
- `start` is ignored in LOAD and DONE. `start` is accepted in the IDLE cycle where `done` = 1 (back-to-back frames).
- Gaps: `sample_valid` low in LOAD stalls the counter, with no write and no timeout.
- `overrun` sets when `sample_valid` = 1 in IDLE or DONE. Those samples are dropped and no write occurs.
- Counter width is ADDR_W+1 internally so that N is detectable; the address uses the low ADDR_W bits only.

## Timing
- Registered write outputs, 1-cycle latency: a sample accepted in cycle k drives `addrA`/`DinA`/`write_enableA` = 1 in cycle k+1.
- `write_enableA` is a single-cycle strobe per accepted sample. `addrA`/`DinA` hold their last values when the strobe is low.
- Last sample accepted in cycle k: the state is DONE and its write is presented in k+1; `done` = 1 in k+2.
- Minimum frame duration from `start` to `done` = N+2 cycles with continuous `sample_valid`.
- `busy` rises the cycle after `start` is sampled and falls in the cycle `done` is high.
- Reset mid-frame: outputs drop to 0 asynchronously and the partial frame is abandoned. No `done` is issued. The RAM contents are don't-care.

## Configuration
- Macro: `SAMPLE_LOADER_BITREV_EN`.
- Defined: `addrA` = bitrev(n), so the RAM is left in FFT input order.
- Undefined: `addrA` = n (natural order); the standalone reorder pass must run before the FFT.
- Handshake, latency and `done` timing are identical in both builds.

## Test plan
All scenarios use ADDR_W=3, DATA_W=32.
- **Continuous frame:** pulse `start`, then present samples 0x00000000..0x00070007 on consecutive cycles with `sample_valid`=1 → writes to addresses 0,4,2,6,1,5,3,7 carrying samples 0..7 in order. `done` pulses exactly 10 cycles after `start` is sampled.
- **Stalled source:** same data with `sample_valid` toggling 1,0,1,0 → identical address/data sequence, no duplicate writes. `done` arrives 1 cycle after the write of the last sample (sample 7).
- **Overrun:** assert `sample_valid` for 2 cycles in IDLE → `overrun`=1, no `write_enableA` pulses. The next `start` clears `overrun` to 0.
- **Back-to-back frames:** assert `start` in the `done` cycle → the second frame begins with no idle gap, and its first write goes to address 0.
- **Reset mid-frame:** drive `reset` low after 3 accepted samples → all outputs 0 immediately. After release, the state is IDLE and the next frame writes address 0 first.
- **Build without `SAMPLE_LOADER_BITREV_EN`:** repeat the continuous-frame scenario → addresses 0..7 in order.
